// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control FSM with memory wait states, illegal-opcode trap and retire counter
module multicycle_ctrl #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [OP_W-1:0]  i_op,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_pc_write_cond,
  output logic             o_branch_ne,
  output logic [1:0]       o_pc_src,
  output logic             o_iord,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_reg_dst,
  output logic             o_reg_write,
  output logic             o_mem_to_reg,
  output logic             o_alu_src_a,
  output logic [2:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic             o_trap,
  output logic             o_instr_done,
  output logic [CNT_W-1:0] o_retired,
  output logic [3:0]       o_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_I  = 4'd4,
    S_EXEC_IZ = 4'd5,
    S_EXEC_B  = 4'd6,
    S_EXEC_J  = 4'd7,
    S_ADDR    = 4'd8,
    S_MEM_RD  = 4'd9,
    S_MEM_WR  = 4'd10,
    S_WB_ALU  = 4'd11,
    S_WB_LW   = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_illegal;
  logic [3:0]       w_low;
  logic             w_unused;

  // The zero flag only matters to the datapath's branch qualifier
  assign w_unused  = i_zero;
  assign w_illegal = (i_op >> 4) != '0;
  assign w_low     = i_op[3:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (o_instr_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next          = r_state;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_branch_ne     = 1'b0;
    o_pc_src        = 2'b00;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = 3'b000;
    o_alu_op        = 2'b00;
    o_trap          = 1'b0;
    o_instr_done    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 3'b001;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_src_b = 3'b100;
        if (w_illegal) w_next = S_TRAP;
        else begin
          case (w_low)
            4'b1000, 4'b1100, 4'b1011, 4'b1111:                   w_next = S_EXEC_R;
            4'b0100, 4'b0101:                                     w_next = S_EXEC_B;
            4'b0011:                                              w_next = S_EXEC_J;
            4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110: w_next = S_EXEC_I;
            4'b0000:                                              w_next = S_EXEC_IZ;
            default:                                              w_next = S_ADDR;
          endcase
        end
      end
      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'b10;
        w_next      = S_WB_ALU;
      end
      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 3'b100;
        o_alu_op    = 2'b10;
        w_next      = S_WB_ALU;
      end
      S_EXEC_IZ: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 3'b011;
        o_alu_op    = 2'b10;
        w_next      = S_WB_ALU;
      end
      S_EXEC_B: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = 2'b01;
        o_pc_src        = 2'b01;
        o_pc_write_cond = 1'b1;
        o_branch_ne     = i_op[0];
        o_instr_done    = 1'b1;
        w_next          = S_FETCH;
      end
      S_EXEC_J: begin
        o_pc_src     = 2'b10;
        o_pc_write   = 1'b1;
        o_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 3'b100;
        w_next      = (w_low == 4'b0001) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        o_iord     = 1'b1;
        o_mem_read = 1'b1;
        if (i_mem_ready) w_next = S_WB_LW;
      end
      S_MEM_WR: begin
        o_iord       = 1'b1;
        o_mem_write  = 1'b1;
        o_instr_done = i_mem_ready;
        if (i_mem_ready) w_next = S_FETCH;
      end
      S_WB_ALU: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_WB_LW: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 1'b1;
        o_mem_to_reg = 1'b1;
        o_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_TRAP: begin
        o_trap     = 1'b1;
        o_pc_src   = 2'b11;
        o_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_retired = r_retired;
  assign o_state   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized and directed checks of multicycle_ctrl against a phase-queue model
module tb_multicycle_ctrl;
  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic       zero = 1'b0;
  logic       mr = 1'b0;
  logic       o_pc_write, o_pc_write_cond, o_branch_ne, o_iord, o_mem_read, o_mem_write, o_ir_write;
  logic       o_reg_dst, o_reg_write, o_mem_to_reg, o_alu_src_a, o_trap, o_instr_done;
  logic [1:0] o_pc_src, o_alu_op;
  logic [2:0] o_alu_src_b;
  logic [3:0] o_retired, o_state;

  int total = 0;
  int bad = 0;
  int m_ph = 0;
  int m_ret = 0;
  iq_t m_q;
  int es[$];
  bit mq[$];
  logic [19:0] cap[$];

  multicycle_ctrl #(.OP_W(6), .CNT_W(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_op(op), .i_zero(zero), .i_mem_ready(mr),
    .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond), .o_branch_ne(o_branch_ne),
    .o_pc_src(o_pc_src), .o_iord(o_iord), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_ir_write(o_ir_write), .o_reg_dst(o_reg_dst), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_trap(o_trap), .o_instr_done(o_instr_done),
    .o_retired(o_retired), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Bit map: 19 pc_write, 18 pc_write_cond, 17 branch_ne, 16:15 pc_src, 14 iord, 13 mem_read,
  // 12 mem_write, 11 ir_write, 10 reg_dst, 9 reg_write, 8 mem_to_reg, 7 alu_src_a,
  // 6:4 alu_src_b, 3:2 alu_op, 1 trap, 0 instr_done
  function automatic logic [19:0] dut_vec();
    return {o_pc_write, o_pc_write_cond, o_branch_ne, o_pc_src, o_iord, o_mem_read, o_mem_write,
            o_ir_write, o_reg_dst, o_reg_write, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
            o_alu_op, o_trap, o_instr_done};
  endfunction

  function automatic logic [19:0] exp_vec(input int ph, input logic [5:0] o, input logic rdy);
    logic [19:0] v;
    v = '0;
    case (ph)
      1:  begin v[13] = 1; v[6:4] = 3'd1; v[11] = rdy; v[19] = rdy; end
      2:  v[6:4] = 3'd4;
      3:  begin v[7] = 1; v[3:2] = 2'd2; end
      4:  begin v[7] = 1; v[6:4] = 3'd4; v[3:2] = 2'd2; end
      5:  begin v[7] = 1; v[6:4] = 3'd3; v[3:2] = 2'd2; end
      6:  begin v[7] = 1; v[3:2] = 2'd1; v[16:15] = 2'd1; v[18] = 1; v[17] = o[0]; v[0] = 1; end
      7:  begin v[16:15] = 2'd2; v[19] = 1; v[0] = 1; end
      8:  begin v[7] = 1; v[6:4] = 3'd4; end
      9:  begin v[14] = 1; v[13] = 1; end
      10: begin v[14] = 1; v[12] = 1; v[0] = rdy; end
      11: begin v[9] = 1; v[0] = 1; end
      12: begin v[9] = 1; v[10] = 1; v[8] = 1; v[0] = 1; end
      13: begin v[1] = 1; v[16:15] = 2'd3; v[19] = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Remaining phases of an instruction once its opcode is decoded
  function automatic iq_t plan(input logic [5:0] o);
    if (o[5:4] != 2'b00) return '{13};
    case (o[3:0])
      4'd8, 4'd12, 4'd11, 4'd15:               return '{3, 11};
      4'd4, 4'd5:                              return '{6};
      4'd3:                                    return '{7};
      4'd9, 4'd10, 4'd13, 4'd14, 4'd7, 4'd6:   return '{4, 11};
      4'd0:                                    return '{5, 11};
      4'd1:                                    return '{8, 9, 12};
      default:                                 return '{8, 10};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    #2;
    if (!rst_n) begin
      chk("rst_outputs", {12'd0, dut_vec()}, 32'd0);
      chk("rst_state", {28'd0, o_state}, 32'd0);
      chk("rst_retired", {28'd0, o_retired}, 32'd0);
      m_ph = 0;
      m_q.delete();
      m_ret = 0;
    end else begin
      e = exp_vec(m_ph, op, mr);
      chk($sformatf("model_out_ph%0d", m_ph), {12'd0, dut_vec()}, {12'd0, e});
      chk("model_state", {28'd0, o_state}, m_ph);
      chk("model_retired", {28'd0, o_retired}, m_ret);
      if (e[0]) m_ret = (m_ret + 1) % 16;
      if (m_ph == 0) m_ph = 1;
      else if (m_ph == 1) begin
        if (mr) m_ph = 2;
      end else if ((m_ph == 9 || m_ph == 10) && !mr) m_ph = m_ph;
      else begin
        if (m_ph == 2) m_q = plan(op);
        m_ph = (m_q.size() != 0) ? m_q.pop_front() : 1;
      end
    end
  end

  task automatic step(input logic [5:0] o, input logic rdy, input logic rn);
    @(negedge clk);
    #1;
    op = o;
    mr = rdy;
    rst_n = rn;
    #2;
  endtask

  task automatic run(input logic [5:0] o, input string nm);
    cap.delete();
    for (int i = 0; i < es.size(); i++) begin
      step(o, mq[i], 1'b1);
      chk($sformatf("%s_state%0d", nm, i), {28'd0, o_state}, es[i]);
      cap.push_back(dut_vec());
    end
  endtask

  function automatic int count_bit(input int b);
    int n = 0;
    foreach (cap[i]) n += cap[i][b];
    return n;
  endfunction

  logic [5:0] rop;
  int r0, done_cnt, adj;

  initial begin
    step(6'd0, 1'b0, 1'b0);
    step(6'd0, 1'b0, 1'b0);
    step(6'd0, 1'b1, 1'b1);
    chk("idle_after_reset", {28'd0, o_state}, 0);
    chk("retired_after_reset", {28'd0, o_retired}, 0);

    es = '{1, 2, 3, 11, 1}; mq = '{1, 1, 1, 1, 0};
    run(6'b001000, "rtype");
    chk("rtype_regwrite_count", count_bit(9), 1);
    chk("rtype_regwrite_wb", {31'd0, cap[3][9]}, 1);
    chk("rtype_retired", {28'd0, o_retired}, 1);

    es = '{1, 2, 8, 9, 9, 9, 12, 1}; mq = '{1, 1, 1, 0, 0, 1, 1, 0};
    run(6'b000001, "load");
    chk("load_iord_rd_cycles", count_bit(14), 3);
    chk("load_memrd_in_memrd", {31'd0, cap[3][13] & cap[4][13] & cap[5][13]}, 1);
    chk("load_wb_sel", {30'd0, cap[6][10], cap[6][8]}, 3);
    chk("load_retired", {28'd0, o_retired}, 2);

    es = '{1, 2, 6, 1}; mq = '{1, 1, 1, 0};
    run(6'b000101, "bne");
    chk("bne_ctl", {28'd0, cap[2][18], cap[2][17], cap[2][16:15]}, 32'hD);
    chk("bne_aluop", {30'd0, cap[2][3:2]}, 1);
    run(6'b000100, "beq");
    chk("beq_ctl", {28'd0, cap[2][18], cap[2][17], cap[2][16:15]}, 32'h9);

    r0 = o_retired;
    es = '{1, 2, 13, 1}; mq = '{1, 1, 1, 0};
    run(6'b011000, "illegal");
    chk("trap_ctl", {28'd0, cap[2][1], cap[2][19], cap[2][16:15]}, 32'hF);
    chk("trap_one_cycle", count_bit(1), 1);
    chk("trap_not_retired", {28'd0, o_retired}, r0);

    es = '{1, 2, 8, 9}; mq = '{1, 1, 1, 0};
    run(6'b000001, "midload");
    step(6'b000001, 1'b0, 1'b0);
    chk("midload_reset_outputs", {12'd0, dut_vec()}, 0);
    chk("midload_reset_state", {28'd0, o_state}, 0);
    step(6'b000001, 1'b0, 1'b1);
    chk("midload_idle", {28'd0, o_state}, 0);
    step(6'b000001, 1'b0, 1'b1);
    chk("midload_fetch", {27'd0, o_state, o_mem_read}, 32'h3);
    chk("midload_retired", {28'd0, o_retired}, 0);

    step(6'd0, 1'b0, 1'b0);
    step(6'd0, 1'b0, 1'b1);
    done_cnt = 0;
    adj = 0;
    es = '{1, 2, 7}; mq = '{1, 1, 1};
    for (int j = 0; j < 17; j++) begin
      run(6'b000011, "jump");
      done_cnt += count_bit(0);
      for (int i = 0; i + 1 < cap.size(); i++) adj += cap[i][0] & cap[i + 1][0];
    end
    step(6'b000011, 1'b0, 1'b1);
    chk("jump_done_pulses", done_cnt, 17);
    chk("jump_done_width", adj, 0);
    chk("jump_retired_wrap", {28'd0, o_retired}, 1);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      #1;
      rst_n = ($urandom_range(0, 299) != 0);
      if (m_ph == 2) begin
        rop[3:0] = 4'($urandom);
        rop[5:4] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        op = rop;
      end else if (m_ph <= 1) op = 6'($urandom);
      mr = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom);
    end
    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
